opp_kick_ctrl: RTL
==================

OPP_KICK_CTRL -- requirements
Module: opp_kick_ctrl

Interface
REQ-001 Parameter OPP_ROD_X, default 480: x pixel column of the opponent kicking rod.
REQ-002 Parameter APPROACH_DIST, default 96: arming window half-width, in pixels.
REQ-003 Parameter CHARGE_FRAMES, default 20: frames the artificial key 6 is held; legal range 1..255.
REQ-004 Parameter COOLDOWN_FRAMES, default 30: frames between a release and re-arming; legal range 1..255.
REQ-005 Port clk, input, 1: system clock.
REQ-006 Port resetN, input, 1: reset, asynchronous, active-low.
REQ-007 Port startOfFrame, input, 1: one-cycle pulse at each frame start.
REQ-008 Port enable, input, 1: opponent AI active when 1.
REQ-009 Port ballTopLeftX, input, 11 signed: ball x position in pixels.
REQ-010 Port BallXSpeed, input, 11 signed: ball x speed; positive means moving toward the opponent rod.
REQ-011 Port collisionWithOppPlayers, input, 1: ball overlaps an opponent player this cycle.
REQ-012 Port goalWasScored, input, 2: 01 or 10 means a goal was scored, 00 otherwise.
REQ-013 Port oppKey_6_is_pressed, output, 1: artificial key-6 hold level.
REQ-014 Port oppKey6WasReleased, output, 1: artificial key-6 release pulse, one cycle wide.
REQ-015 Port kickCount, output, 8: number of completed releases, saturating.
REQ-016 Port state_o, output, 3: current FSM state encoding, for debug.

Function
REQ-017 The block SHALL implement the states IDLE=0, ARMED=1, CHARGE=2, RELEASE=3 and COOLDOWN=4.
REQ-018 All outputs SHALL be registered, and every state change SHALL take effect one clk edge after its condition is sampled.
REQ-019 The block SHALL compute dist = |ballTopLeftX - OPP_ROD_X| at 12-bit signed width, with no overflow for any 11-bit input.
REQ-020 inWin SHALL be true when dist <= APPROACH_DIST and BallXSpeed > 0.
REQ-021 IDLE SHALL go to ARMED when inWin is true.
REQ-022 ARMED SHALL go to CHARGE when collisionWithOppPlayers is 1, and that condition SHALL take priority over inWin.
REQ-023 ARMED SHALL go to IDLE when collisionWithOppPlayers is 0 and inWin is false.
REQ-024 On entry to CHARGE, the frame counter SHALL clear to 0.
REQ-025 In CHARGE, each startOfFrame SHALL increment the frame counter.
REQ-026 CHARGE SHALL go to RELEASE on the startOfFrame at which the counter becomes CHARGE_FRAMES.
REQ-027 The CHARGE-to-RELEASE transition SHALL NOT depend on collisionWithOppPlayers.
REQ-028 RELEASE SHALL last exactly one cycle and then go to COOLDOWN.
REQ-029 On entry to COOLDOWN, the frame counter SHALL clear to 0.
REQ-030 COOLDOWN SHALL go to IDLE on the startOfFrame at which the counter becomes COOLDOWN_FRAMES.
REQ-031 oppKey_6_is_pressed SHALL be 1 exactly while the state is CHARGE.
REQ-032 oppKey6WasReleased SHALL be 1 exactly while the state is RELEASE.
REQ-033 oppKey_6_is_pressed and oppKey6WasReleased SHALL never both be 1.
REQ-034 In each RELEASE cycle, kickCount SHALL increment by 1 and hold at 255 without wrapping.
REQ-035 Abort: when goalWasScored != 00 or enable = 0, the next state SHALL be IDLE from any state.
REQ-036 An abort from CHARGE SHALL NOT generate a release pulse.
REQ-037 Abort SHALL clear the frame counter and SHALL override every other transition in the same cycle.
REQ-038 An abort while in RELEASE SHALL still complete that cycle's pulse and kickCount increment, and the next state SHALL be IDLE.
REQ-039 A startOfFrame on the same cycle as entry to CHARGE or COOLDOWN SHALL NOT be counted.
REQ-040 goalWasScored = 11 SHALL be treated as an abort.

Reset
REQ-041 While resetN = 0, the state SHALL be IDLE and the frame counter SHALL be 0.
REQ-042 While resetN = 0, oppKey_6_is_pressed, oppKey6WasReleased and kickCount SHALL be 0.
REQ-043 Reset asserted mid-CHARGE SHALL drop oppKey_6_is_pressed immediately (asynchronously), with no release pulse.

Verification
REQ-044 Scenario nominal kick: ballX=400, speed=+150, enable=1, collision on the 5th cycle -> ARMED, then CHARGE; pressed for exactly 20 frames; one release pulse; kickCount=1; IDLE after 30 frames.
REQ-045 Scenario window miss: ballX=300 (dist 180), speed=+150; separately ballX=450, speed=-20 -> the state stays IDLE in both cases; outputs stay 0.
REQ-046 Scenario abort: goalWasScored=01 at charge frame 10 -> pressed=0 on the next cycle; no release pulse; IDLE; kickCount unchanged.
REQ-047 Scenario arm lost: in ARMED, ballX moves to 600 with no collision -> IDLE on the next cycle.
REQ-048 Scenario saturation: 256 nominal kicks -> kickCount=255, and it stays 255 after a 257th kick.
REQ-049 Scenario async reset mid-CHARGE: resetN=0 -> pressed=0 without waiting for clk; no pulse; IDLE after reset release.

Source files
------------

// File: rtl/opp_kick_ctrl.sv
// Opponent AI kick controller: arms when the ball approaches the opponent rod,
// holds an artificial key 6 for a fixed number of frames, then emits a release pulse.
module opp_kick_ctrl #(
   parameter int OPP_ROD_X       = 480,
   parameter int APPROACH_DIST   = 96,
   parameter int CHARGE_FRAMES   = 20,
   parameter int COOLDOWN_FRAMES = 30
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               enable,
   input  logic signed [10:0] ballTopLeftX,
   input  logic signed [10:0] BallXSpeed,
   input  logic               collisionWithOppPlayers,
   input  logic [1:0]         goalWasScored,
   output logic               oppKey_6_is_pressed,
   output logic               oppKey6WasReleased,
   output logic [7:0]         kickCount,
   output logic [2:0]         state_o
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned POS_W = 12;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARMED    = 3'd1,
      S_CHARGE   = 3'd2,
      S_RELEASE  = 3'd3,
      S_COOLDOWN = 3'd4
   } state_t;

   state_t                   r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         r_kick;
   logic                     r_pressed;
   logic                     r_released;

   logic signed [POS_W-1:0]  w_diff;
   logic signed [POS_W-1:0]  w_dist;
   logic                     w_in_win;
   logic                     w_abort;
   logic [CNT_W-1:0]         w_cnt_inc;

   // 12-bit signed distance covers the whole 11-bit ball range without overflow
   assign w_diff    = $signed({ballTopLeftX[10], ballTopLeftX}) - $signed(POS_W'(OPP_ROD_X));
   assign w_dist    = w_diff[POS_W-1] ? -w_diff : w_diff;
   assign w_in_win  = (w_dist <= $signed(POS_W'(APPROACH_DIST))) && (BallXSpeed > 11'sd0);
   assign w_abort   = (goalWasScored != 2'b00) || !enable;
   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // Key outputs are registered alongside the state they mirror
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_kick     <= '0;
         r_pressed  <= 1'b0;
         r_released <= 1'b0;
      end else begin
         r_pressed  <= 1'b0;
         r_released <= 1'b0;
         if (w_abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_in_win) r_state <= S_ARMED;
               end
               S_ARMED: begin
                  if (collisionWithOppPlayers) begin
                     r_state   <= S_CHARGE;
                     r_cnt     <= '0;
                     r_pressed <= 1'b1;
                  end else if (!w_in_win) begin
                     r_state <= S_IDLE;
                  end
               end
               S_CHARGE: begin
                  if (startOfFrame && (w_cnt_inc == CNT_W'(CHARGE_FRAMES))) begin
                     r_state    <= S_RELEASE;
                     r_cnt      <= w_cnt_inc;
                     r_released <= 1'b1;
                     // kickCount saturates at 255
                     if (r_kick != '1) r_kick <= r_kick + CNT_W'(1);
                  end else begin
                     r_pressed <= 1'b1;
                     if (startOfFrame) r_cnt <= w_cnt_inc;
                  end
               end
               S_RELEASE: begin
                  r_state <= S_COOLDOWN;
                  r_cnt   <= '0;
               end
               S_COOLDOWN: begin
                  if (startOfFrame) begin
                     r_cnt <= w_cnt_inc;
                     if (w_cnt_inc == CNT_W'(COOLDOWN_FRAMES)) r_state <= S_IDLE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign oppKey_6_is_pressed = r_pressed;
   assign oppKey6WasReleased  = r_released;
   assign kickCount           = r_kick;
   assign state_o             = r_state;

endmodule
